// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } ifq_entry_t;

  // J/JAL target: upper nibble of the delay-slot PC, then instr_index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    return {nxt[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// In-order prefetch buffer: DEPTH entries, power-of-2 pointers, synchronous flush.
module ifq_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  ifq_entry_t    data_i,
  input  logic          pop_i,
  output ifq_entry_t    head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  ifq_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: PC, credit-limited imem requests, prefetch queue, IF/ID register.
// Optional `IFQ_BYPASS_EN lets a response skip an empty queue straight into IF/ID.
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AnyStall,
  input  logic        Jump_ID,
  input  logic [25:0] JumpTgt_ID,
  input  logic        BranchTaken_EX,
  input  logic [31:0] RedirectPc_EX,
  output logic        ImemReq_IF,
  output logic [31:0] ImemAddr_IF,
  input  logic        ImemGnt_IF,
  input  logic        ImemRspValid_IF,
  input  logic [31:0] ImemRspData_IF,
  output logic [31:0] FetchData_IF,
  output logic        FetchValid_IF,
  output logic [31:0] FetchPc_IF
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic          redirect_s, req_s, fire_s, rsp_ok_s, drop_hit_s, live_rsp_s;
  logic          push_s, pop_s, bypass_s, empty_s;
  logic [31:0]   target_s;
  logic [CW-1:0] count_s;
  ifq_entry_t    head_s, wr_entry_s;

  logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [31:0]   fdata_q, fdata_d, fpc_q, fpc_d;
  logic          fvalid_q, fvalid_d;

  // Branch is older than the jump in decode, so it wins.
  assign redirect_s = BranchTaken_EX | Jump_ID;
  assign target_s   = BranchTaken_EX ? RedirectPc_EX : jump_target(fpc_q, JumpTgt_ID);

  assign req_s      = !redirect_s && ((32'(count_s) + 32'(outst_q)) < 32'(DEPTH))
                      && (32'(outst_q) < 32'(MAX_OUTST));
  assign fire_s     = req_s && ImemGnt_IF;
  assign rsp_ok_s   = ImemRspValid_IF && (outst_q != '0);
  assign drop_hit_s = rsp_ok_s && (drop_q != '0);
  assign live_rsp_s = rsp_ok_s && !drop_hit_s && !redirect_s;
  assign wr_entry_s = '{instr: ImemRspData_IF, pc: rsp_pc_q};

`ifdef IFQ_BYPASS_EN
  assign bypass_s = live_rsp_s && empty_s && !AnyStall;
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s = live_rsp_s && !bypass_s;
  assign pop_s  = !redirect_s && !AnyStall && !empty_s;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (redirect_s),
    .push_i  (push_s),
    .data_i  (wr_entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (count_s),
    .empty_o (empty_s)
  );

  assign ImemReq_IF    = req_s;
  assign ImemAddr_IF   = pc_q;
  assign FetchData_IF  = fdata_q;
  assign FetchValid_IF = fvalid_q;
  assign FetchPc_IF    = fpc_q;

  always_comb begin
    pc_d     = fire_s ? (pc_q + 32'd4) : pc_q;
    rsp_pc_d = live_rsp_s ? (rsp_pc_q + 32'd4) : rsp_pc_q;
    outst_d  = outst_q + OW'(fire_s) - OW'(rsp_ok_s);
    drop_d   = drop_q - OW'(drop_hit_s);
    fdata_d  = fdata_q;
    fvalid_d = fvalid_q;
    fpc_d    = fpc_q;
    if (redirect_s) begin
      // Every in-flight response is now stale; pending drops are already part of Outst.
      pc_d     = target_s;
      rsp_pc_d = target_s;
      drop_d   = outst_q - OW'(rsp_ok_s);
      fdata_d  = NOP_INSTR;
      fvalid_d = 1'b0;
      fpc_d    = 32'h0000_0000;
    end else if (!AnyStall) begin
      if (bypass_s) begin
        fdata_d  = ImemRspData_IF;
        fvalid_d = 1'b1;
        fpc_d    = rsp_pc_q;
      end else if (!empty_s) begin
        fdata_d  = head_s.instr;
        fvalid_d = 1'b1;
        fpc_d    = head_s.pc;
      end else begin
        fdata_d  = NOP_INSTR;
        fvalid_d = 1'b0;
        fpc_d    = 32'h0000_0000;
      end
    end else begin
      fdata_d  = fdata_q;
      fvalid_d = fvalid_q;
      fpc_d    = fpc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      fdata_q  <= NOP_INSTR;
      fvalid_q <= 1'b0;
      fpc_q    <= 32'h0000_0000;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      fdata_q  <= fdata_d;
      fvalid_q <= fvalid_d;
      fpc_q    <= fpc_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && ImemRspValid_IF && (outst_q == '0))
      $error("ifetch_queue: imem response with no request outstanding");
  end
`endif

endmodule
